// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: memory-wait freeze, branch flush, load-use and RAW stalls, operand forwarding.
// Define HAZARD_FWD_EN to enable forwarding; without it RAW hazards are resolved by draining (DRAIN state).

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_R_1_num,
  input  logic [4:0]       D_R_2_num,
  input  logic [4:0]       E_R_1_num,
  input  logic [4:0]       E_R_2_num,
  input  logic [4:0]       E_DR_num,
  input  logic             E_MemRead,
  input  logic             E_RegWrite,
  input  logic [4:0]       M_DR_num,
  input  logic             M_RegWrite,
  input  logic             M_MemAccess,
  input  logic [4:0]       W_DR_num,
  input  logic             W_RegWrite,
  input  logic             E_PCSrc,
  input  logic             dmem_ready,
  output logic             PC_EN,
  output logic             FD_EN,
  output logic             DE_EN,
  output logic             EM_EN,
  output logic             FD_FLUSH,
  output logic             DE_FLUSH,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [9:0] LP_TIMEOUT = 10'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  logic [9:0]       r_wait_cnt;
  logic [9:0]       w_wait_inc;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_freeze;
  logic             w_load_use;
  logic             w_raw_hit;

  assign w_load_use = E_MemRead && (E_DR_num != 5'd0) &&
                      ((E_DR_num == D_R_1_num) || (E_DR_num == D_R_2_num));

`ifdef HAZARD_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = E_RegWrite;
  assign w_raw_hit    = 1'b0;

  // Memory-stage result is younger than writeback, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    if (M_RegWrite && (M_DR_num != 5'd0) && (M_DR_num == E_R_1_num))      fwd_a = 2'b10;
    else if (W_RegWrite && (W_DR_num != 5'd0) && (W_DR_num == E_R_1_num)) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (M_RegWrite && (M_DR_num != 5'd0) && (M_DR_num == E_R_2_num))      fwd_b = 2'b10;
    else if (W_RegWrite && (W_DR_num != 5'd0) && (W_DR_num == E_R_2_num)) fwd_b = 2'b01;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{E_R_1_num, E_R_2_num, W_DR_num, W_RegWrite};
  assign fwd_a        = 2'b00;
  assign fwd_b        = 2'b00;

  // Writeback matches are not hazards: the register file writes before decode reads.
  assign w_raw_hit =
    ((D_R_1_num != 5'd0) && ((E_RegWrite && (D_R_1_num == E_DR_num)) ||
                             (M_RegWrite && (D_R_1_num == M_DR_num)))) ||
    ((D_R_2_num != 5'd0) && ((E_RegWrite && (D_R_2_num == E_DR_num)) ||
                             (M_RegWrite && (D_R_2_num == M_DR_num))));
`endif

  // Once waiting, only dmem_ready releases the freeze; the held M stage keeps M_MemAccess.
  assign w_freeze   = (r_state == MEMWAIT) ? !dmem_ready : (M_MemAccess && !dmem_ready);
  assign w_wait_inc = (r_wait_cnt == 10'h3FF) ? r_wait_cnt : r_wait_cnt + 10'd1;

  // NOTE: every output gets a default before the priority chain so no path infers a latch.
  always_comb begin
    PC_EN        = 1'b1;
    FD_EN        = 1'b1;
    DE_EN        = 1'b1;
    EM_EN        = 1'b1;
    FD_FLUSH     = 1'b0;
    DE_FLUSH     = 1'b0;
    w_state_next = RUN;
    if (!reset) begin
      w_state_next = RUN;
    end else if (w_freeze) begin
      PC_EN        = 1'b0;
      FD_EN        = 1'b0;
      DE_EN        = 1'b0;
      EM_EN        = 1'b0;
      w_state_next = MEMWAIT;
    end else if (E_PCSrc) begin
      FD_FLUSH     = 1'b1;
      DE_FLUSH     = 1'b1;
      w_state_next = RUN;
    end else if (w_load_use || w_raw_hit) begin
      PC_EN        = 1'b0;
      FD_EN        = 1'b0;
      DE_FLUSH     = 1'b1;
      w_state_next = w_raw_hit ? DRAIN : RUN;
    end
  end

  // NOTE: state and counters use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state != MEMWAIT) && w_freeze) begin
        r_wait_cnt <= '0;
      end else if (r_state == MEMWAIT) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == LP_TIMEOUT) r_mem_err <= 1'b1;
      end
      if (!PC_EN && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FD_FLUSH && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized stimulus against a rule-level model.
// Expectations follow HAZARD_FWD_EN the same way the design does.

module tb_hazard_ctrl;

  localparam int TO  = 3;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    D_R_1_num, D_R_2_num, E_R_1_num, E_R_2_num, E_DR_num, M_DR_num, W_DR_num;
  logic          E_MemRead, E_RegWrite, M_RegWrite, M_MemAccess, W_RegWrite, E_PCSrc, dmem_ready;
  logic          PC_EN, FD_EN, DE_EN, EM_EN, FD_FLUSH, DE_FLUSH, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic [9:0]    got_ctrl;
  logic [8:0]    got_st;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_wait, m_err;
  int m_wlen, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_R_1_num(D_R_1_num), .D_R_2_num(D_R_2_num),
    .E_R_1_num(E_R_1_num), .E_R_2_num(E_R_2_num), .E_DR_num(E_DR_num),
    .E_MemRead(E_MemRead), .E_RegWrite(E_RegWrite),
    .M_DR_num(M_DR_num), .M_RegWrite(M_RegWrite), .M_MemAccess(M_MemAccess),
    .W_DR_num(W_DR_num), .W_RegWrite(W_RegWrite),
    .E_PCSrc(E_PCSrc), .dmem_ready(dmem_ready),
    .PC_EN(PC_EN), .FD_EN(FD_EN), .DE_EN(DE_EN), .EM_EN(EM_EN),
    .FD_FLUSH(FD_FLUSH), .DE_FLUSH(DE_FLUSH), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign got_ctrl = {PC_EN, FD_EN, DE_EN, EM_EN, FD_FLUSH, DE_FLUSH, fwd_a, fwd_b};
  assign got_st   = {mem_err, stall_cnt, flush_cnt};

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (M_RegWrite && M_DR_num != 0 && M_DR_num == src) return 2'b10;
    if (W_RegWrite && W_DR_num != 0 && W_DR_num == src) return 2'b01;
    return 2'b00;
  endfunction
`endif

  // Expected {PC,FD,DE,EM enables, FD/DE flush, fwd_a, fwd_b} from the hazard rules.
  function automatic logic [9:0] exp_ctrl();
    logic       ld, hit, frz;
    logic [3:0] en, fw;
    logic [1:0] fl;
    logic [4:0] srcs [2];
    srcs[0] = D_R_1_num;
    srcs[1] = D_R_2_num;
    ld = 1'b0;
    foreach (srcs[i])
      if (E_MemRead && E_DR_num != 0 && srcs[i] == E_DR_num) ld = 1'b1;
    hit = ld;
`ifdef HAZARD_FWD_EN
    fw = {fsel(E_R_1_num), fsel(E_R_2_num)};
`else
    fw = 4'b0000;
    foreach (srcs[i])
      if (srcs[i] != 0 && ((E_RegWrite && srcs[i] == E_DR_num) ||
                           (M_RegWrite && srcs[i] == M_DR_num))) hit = 1'b1;
`endif
    frz = m_wait ? !dmem_ready : (M_MemAccess && !dmem_ready);
    if (!reset)       begin en = 4'b1111; fl = 2'b00; end
    else if (frz)     begin en = 4'b0000; fl = 2'b00; end
    else if (E_PCSrc) begin en = 4'b1111; fl = 2'b11; end
    else if (hit)     begin en = 4'b0011; fl = 2'b01; end
    else              begin en = 4'b1111; fl = 2'b00; end
    return {en, fl, fw};
  endfunction

  task automatic model_clear();
    m_wait = 0; m_err = 0; m_wlen = 0; m_stall = 0; m_flush = 0;
  endtask

  // Advance one clock with the current inputs, updating the model at the rising edge.
  task automatic cyc();
    logic [9:0] e;
    logic       frz;
    e   = exp_ctrl();
    frz = reset && (m_wait ? !dmem_ready : (M_MemAccess && !dmem_ready));
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (m_wait) begin
        if (m_wlen < 1023) m_wlen++;
        if (m_wlen == TO) m_err = 1;
        if (dmem_ready) m_wait = 0;
      end else if (frz) begin
        m_wait = 1;
        m_wlen = 0;
      end
      if (!e[9] && m_stall < MAX) m_stall++;
      if (e[5] && m_flush < MAX) m_flush++;
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    {D_R_1_num, D_R_2_num, E_R_1_num, E_R_2_num, E_DR_num, M_DR_num, W_DR_num} = '0;
    {E_MemRead, E_RegWrite, M_RegWrite, M_MemAccess, W_RegWrite, E_PCSrc} = '0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    clear_in();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_in();
    E_MemRead = 1; E_RegWrite = 1; E_DR_num = 5; D_R_1_num = 5;
    M_MemAccess = 1; dmem_ready = 0;
    #1;
    if (got_ctrl[9:4] !== 6'b111100) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", got_ctrl[9:4], 6'b111100);
    end
    n_checks++;
    @(negedge clk); @(negedge clk);
    #1;
    if (got_st !== 9'd0) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", got_st, 9'd0);
    end
    n_checks++;
    clear_in();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_load_use();
    do_reset();
    E_MemRead = 1; E_RegWrite = 1; E_DR_num = 5; D_R_1_num = 9; D_R_2_num = 5;
    #1;
    if (got_ctrl[9:4] !== 6'b001101) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected %b", got_ctrl[9:4], 6'b001101);
    end
    n_checks++;
    cyc();
    clear_in();
    #1;
    if (got_ctrl[9:4] !== 6'b111100 || stall_cnt !== 4'd1) begin
      n_fail++; $display("FAIL load_use_release: got %b cnt %0d expected 111100 cnt 1", got_ctrl[9:4], stall_cnt);
    end
    n_checks++;
    E_MemRead = 1; E_RegWrite = 1; E_DR_num = 0; M_RegWrite = 1;
    #1;
    if (got_ctrl[9:4] !== 6'b111100) begin
      n_fail++; $display("FAIL x0_no_stall: got %b expected %b", got_ctrl[9:4], 6'b111100);
    end
    n_checks++;
    clear_in();
  endtask

  task automatic test_flush_priority();
    do_reset();
    E_MemRead = 1; E_RegWrite = 1; E_DR_num = 4; D_R_1_num = 4; E_PCSrc = 1;
    #1;
    if (got_ctrl[9:4] !== 6'b111111) begin
      n_fail++; $display("FAIL flush_over_stall: got %b expected %b", got_ctrl[9:4], 6'b111111);
    end
    n_checks++;
    cyc();
    clear_in();
    #1;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL flush_count: got flush %0d stall %0d expected 1 0", flush_cnt, stall_cnt);
    end
    n_checks++;
  endtask

  task automatic test_memwait_branch();
    do_reset();
    M_MemAccess = 1; dmem_ready = 0; E_PCSrc = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (got_ctrl[9:4] !== 6'b000000) begin
        n_fail++; $display("FAIL memwait_freeze[%0d]: got %b expected %b", i, got_ctrl[9:4], 6'b000000);
      end
      n_checks++;
      cyc();
    end
    dmem_ready = 1;
    #1;
    if (got_ctrl[9:4] !== 6'b111111) begin
      n_fail++; $display("FAIL memwait_release_flush: got %b expected %b", got_ctrl[9:4], 6'b111111);
    end
    n_checks++;
    cyc();
    clear_in();
    #1;
    if (got_st !== {1'b1, 4'd4, 4'd1}) begin
      n_fail++; $display("FAIL memwait_counts: got %h expected %h", got_st, {1'b1, 4'd4, 4'd1});
    end
    n_checks++;
  endtask

  task automatic test_timeout();
    do_reset();
    M_MemAccess = 1; dmem_ready = 0;
    cyc(); cyc(); cyc();
    #1;
    if (mem_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b expected 0", mem_err);
    end
    n_checks++;
    cyc();
    #1;
    if (mem_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_set: got %b expected 1", mem_err);
    end
    n_checks++;
    dmem_ready = 1;
    cyc();
    clear_in();
    cyc();
    #1;
    if (mem_err !== 1'b1 || stall_cnt !== 4'd4 || got_ctrl[9:4] !== 6'b111100) begin
      n_fail++; $display("FAIL timeout_sticky: got err %b stall %0d ctrl %b expected 1 4 111100", mem_err, stall_cnt, got_ctrl[9:4]);
    end
    n_checks++;
    #2 reset = 1'b0;
    model_clear();
    #1;
    if (got_st !== 9'd0) begin
      n_fail++; $display("FAIL async_reset_clear: got %h expected %h", got_st, 9'd0);
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    M_MemAccess = 1; dmem_ready = 0;
    cyc(); cyc();
    #2 reset = 1'b0;
    model_clear();
    #1;
    if (got_ctrl[9:4] !== 6'b111100 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_wait: got %b err %b expected 111100 err 0", got_ctrl[9:4], mem_err);
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    M_MemAccess = 0; dmem_ready = 0;
    #1;
    if (got_ctrl[9:4] !== 6'b111100) begin
      n_fail++; $display("FAIL wait_abandoned: got %b expected %b", got_ctrl[9:4], 6'b111100);
    end
    n_checks++;
    clear_in();
  endtask

  task automatic test_forward();
    logic [1:0] e_m, e_w;
`ifdef HAZARD_FWD_EN
    e_m = 2'b10; e_w = 2'b01;
`else
    e_m = 2'b00; e_w = 2'b00;
`endif
    do_reset();
    M_DR_num = 7; W_DR_num = 7; E_R_1_num = 7; M_RegWrite = 1; W_RegWrite = 1;
    #1;
    if (fwd_a !== e_m) begin
      n_fail++; $display("FAIL fwd_mem_priority: got %b expected %b", fwd_a, e_m);
    end
    n_checks++;
    M_DR_num = 0; W_DR_num = 0; E_R_2_num = 0;
    #1;
    if (fwd_b !== 2'b00 || fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL fwd_x0: got %b %b expected 00 00", fwd_a, fwd_b);
    end
    n_checks++;
    M_RegWrite = 0; M_DR_num = 6; W_DR_num = 6; E_R_2_num = 6;
    #1;
    if (fwd_b !== e_w) begin
      n_fail++; $display("FAIL fwd_wb: got %b expected %b", fwd_b, e_w);
    end
    n_checks++;
    clear_in();
  endtask

  task automatic test_drain();
    logic [5:0] e_st;
    int         e_cnt;
`ifdef HAZARD_FWD_EN
    e_st = 6'b111100; e_cnt = 0;
`else
    e_st = 6'b001101; e_cnt = 2;
`endif
    do_reset();
    E_RegWrite = 1; E_DR_num = 3; D_R_1_num = 3;
    #1;
    if (got_ctrl[9:4] !== e_st) begin
      n_fail++; $display("FAIL drain_e_match: got %b expected %b", got_ctrl[9:4], e_st);
    end
    n_checks++;
    cyc();
    clear_in();
    M_RegWrite = 1; M_DR_num = 3; D_R_1_num = 3;
    #1;
    if (got_ctrl[9:4] !== e_st) begin
      n_fail++; $display("FAIL drain_m_match: got %b expected %b", got_ctrl[9:4], e_st);
    end
    n_checks++;
    cyc();
    clear_in();
    W_RegWrite = 1; W_DR_num = 3; D_R_1_num = 3;
    #1;
    if (got_ctrl[9:4] !== 6'b111100 || stall_cnt !== 4'(e_cnt)) begin
      n_fail++; $display("FAIL drain_done: got %b cnt %0d expected 111100 cnt %0d", got_ctrl[9:4], stall_cnt, e_cnt);
    end
    n_checks++;
    clear_in();
  endtask

  task automatic test_saturate();
    do_reset();
    E_MemRead = 1; E_RegWrite = 1; E_DR_num = 2; D_R_2_num = 2;
    for (int i = 0; i < 14; i++) cyc();
    #1;
    if (stall_cnt !== 4'hE) begin
      n_fail++; $display("FAIL stall_cnt_14: got %h expected %h", stall_cnt, 4'hE);
    end
    n_checks++;
    for (int i = 0; i < 6; i++) cyc();
    #1;
    if (stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL stall_cnt_sat: got %h expected %h", stall_cnt, 4'hF);
    end
    n_checks++;
    E_PCSrc = 1;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    if (flush_cnt !== 4'hF || stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL flush_cnt_sat: got %h %h expected F F", flush_cnt, stall_cnt);
    end
    n_checks++;
    clear_in();
  endtask

  task automatic test_random();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      D_R_1_num   = 5'($urandom_range(0, 3));
      D_R_2_num   = 5'($urandom_range(0, 3));
      E_R_1_num   = 5'($urandom_range(0, 3));
      E_R_2_num   = 5'($urandom_range(0, 3));
      E_DR_num    = 5'($urandom_range(0, 3));
      M_DR_num    = 5'($urandom_range(0, 3));
      W_DR_num    = 5'($urandom_range(0, 3));
      E_MemRead   = ($urandom_range(0, 2) == 0);
      E_RegWrite  = ($urandom_range(0, 1) == 0);
      M_RegWrite  = ($urandom_range(0, 1) == 0);
      W_RegWrite  = ($urandom_range(0, 1) == 0);
      M_MemAccess = ($urandom_range(0, 2) == 0);
      dmem_ready  = ($urandom_range(0, 3) != 0);
      E_PCSrc     = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 149) != 0);
      if (!reset) model_clear();
      #1;
      e = exp_ctrl();
      if (got_ctrl !== e) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, got_ctrl, e);
      end
      n_checks++;
      if (got_st !== {m_err, 4'(m_stall), 4'(m_flush)}) begin
        n_fail++; $display("FAIL rand_status[%0d]: got %h expected %h", i, got_st, {m_err, 4'(m_stall), 4'(m_flush)});
      end
      n_checks++;
      cyc();
    end
    reset = 1'b1;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush_priority();
    test_memwait_branch();
    test_timeout();
    test_forward();
    test_drain();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, memory-wait cycles before mem_err sets (range 1..1023).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have ports clk  in  1  sole clock, rising edge; and reset  in  1  asynchronous, active-low.
REQ-004 SHALL have ports D_R_1_num, D_R_2_num  in  5 each  decode-stage source register numbers.
REQ-005 SHALL have ports E_R_1_num, E_R_2_num, E_DR_num  in  5 each  execute-stage sources and destination; E_MemRead, E_RegWrite  in  1 each.
REQ-006 SHALL have ports M_DR_num  in  5; M_RegWrite, M_MemAccess  in  1 each  memory-stage destination and load/store flag.
REQ-007 SHALL have ports W_DR_num  in  5; W_RegWrite  in  1  writeback destination.
REQ-008 SHALL have ports E_PCSrc  in  1  taken branch or jump resolved in execute; dmem_ready  in  1  data memory done.
REQ-009 SHALL have ports PC_EN, FD_EN, DE_EN, EM_EN  out  1 each  stage-register enables (DE_EN drives the decode-stage EN).
REQ-010 SHALL have ports FD_FLUSH, DE_FLUSH  out  1 each  bubble insert; fwd_a, fwd_b  out  2 each  ALU operand select.
REQ-011 SHALL have ports mem_err  out  1  sticky timeout flag; stall_cnt, flush_cnt  out  CNT_W each.

Function
REQ-012 SHALL implement FSM states RUN, MEMWAIT and DRAIN in a registered state; all enables, flushes and forward selects SHALL be combinational from the state and current inputs (zero latency).
REQ-013 RUN -> MEMWAIT when M_MemAccess=1 and dmem_ready=0; MEMWAIT -> RUN on the first cycle dmem_ready=1.
REQ-014 In MEMWAIT: PC_EN=FD_EN=DE_EN=EM_EN=0, no flushes; in the cycle dmem_ready=1 is seen the normal RUN equations SHALL apply.
REQ-015 Flush priority: in RUN with E_PCSrc=1 -> FD_FLUSH=DE_FLUSH=1, all enables 1, for exactly that cycle; flush overrides any load-use stall in the same cycle.
REQ-016 Branch during memory wait: freeze wins; E_PCSrc is held by the frozen execute stage and the flush SHALL occur in the release cycle.
REQ-017 Load-use: E_MemRead=1, E_DR_num!=0 and E_DR_num equals D_R_1_num or D_R_2_num -> PC_EN=FD_EN=0, DE_FLUSH=1, EM_EN=1, for one cycle.
REQ-018 fwd_a=2'b10 if M_RegWrite, M_DR_num!=0 and M_DR_num==E_R_1_num; else 2'b01 if W_RegWrite, W_DR_num!=0 and W_DR_num==E_R_1_num; else 2'b00; memory stage has priority; fwd_b identical using E_R_2_num.
REQ-019 Register x0 SHALL never cause a stall or forward.
REQ-020 wait_cnt (10 bit) SHALL clear on MEMWAIT entry, increment each MEMWAIT cycle, saturate; mem_err SHALL set when wait_cnt reaches MEM_TIMEOUT and hold until reset; the FSM keeps waiting.
REQ-021 stall_cnt SHALL increment on every cycle with PC_EN=0; flush_cnt on every cycle with FD_FLUSH=1; both saturate at all-ones, never wrap.

Reset
REQ-022 reset=0 SHALL immediately force state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-023 During reset all enables SHALL be 1 and flushes 0; reset asserted mid-MEMWAIT SHALL abandon the wait with no error.

Configuration
REQ-024 Macro HAZARD_FWD_EN defined: forwarding per REQ-018; state DRAIN unused.
REQ-025 HAZARD_FWD_EN undefined: fwd_a=fwd_b=2'b00; any decode source (non-zero) matching E_DR_num with E_RegWrite or M_DR_num with M_RegWrite SHALL enter DRAIN, which applies REQ-017 stall outputs each cycle until no match, then returns to RUN; writeback matches do not stall; MEMWAIT and flush take priority over DRAIN.

Verification
REQ-026 Load x5 in E, D_R_2_num=5 -> one cycle PC_EN=0, FD_EN=0, DE_FLUSH=1; next cycle all enables 1; stall_cnt=1.
REQ-027 M_MemAccess=1, dmem_ready=0 for 4 cycles, with E_PCSrc=1 -> all enables 0 for 4 cycles, then FD_FLUSH=DE_FLUSH=1 in the release cycle; flush_cnt=1.
REQ-028 MEM_TIMEOUT=3, dmem_ready held 0 -> mem_err=1 after the 3rd MEMWAIT cycle, remains 1 after dmem_ready; reset=0 clears it asynchronously.
REQ-029 M_DR_num=W_DR_num=E_R_1_num=7, both RegWrite -> fwd_a=2'b10; E_R_2_num=0 with M_DR_num=0 -> fwd_b=2'b00.
REQ-030 Without HAZARD_FWD_EN: add x3 in E, D_R_1_num=3 -> two stall cycles (E then M match), third cycle RUN with enables 1.
REQ-031 CNT_W=4, 20 consecutive stall cycles -> stall_cnt=4'hF, no wrap.
